// File: rtl/memory_mmio_v2.sv
// Memory-mapped RAM / seven-segment / switch / button unit with a valid-ready request/response port.
// Optional build macro MMIO_SEG_DECODE_EN: seven-segment channels hold a hex nibble and drive decoded active-low patterns.
module memory_mmio_v2 #(
  parameter int DEPTH_WORDS     = 256,
  parameter int NUM_SEG         = 8,
  parameter int NUM_SW          = 16,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  input  logic [NUM_SW-1:0]    switch_array,
  input  logic [NUM_BTN-1:0]   buttons,
  output logic [NUM_SEG*7-1:0] seg,
  output logic [7:0]           error_vector
);
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int NIN = NUM_SW + NUM_BTN;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef MMIO_SEG_DECODE_EN
  localparam int SEG_W = 4;
`else
  localparam int SEG_W = 7;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [31:0]      ram [DEPTH_WORDS];
  logic [SEG_W-1:0] seg_val [NUM_SEG];
  logic [NIN-1:0]   sync1, sync2, level, level_nxt;
  logic [CW-1:0]    cnt [NIN];
  logic [CW-1:0]    cnt_nxt [NIN];
  logic [NUM_BTN-1:0] edges, edges_nxt, rise;
  logic [3:0]       status, status_nxt, errs;
  logic [NUM_SEG-1:0] seg_hit;
  logic [15:0]      seg_k;
  logic [31:0]      rd_data;
  logic ram_hit, sw_hit, btn_hit, edge_hit, stat_hit, any_err, accept, do_wr, do_rd;

  // Input conditioning: two-flop synchroniser, then per-bit stability counter
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < NIN; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != level[i]) begin
        if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) level_nxt[i] = sync2[i];
        else cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {buttons, switch_array};
      sync2 <= sync1;
      level <= level_nxt;
      for (int i = 0; i < NIN; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign rise = level_nxt[NIN-1:NUM_SW] & ~level[NIN-1:NUM_SW];

  // Address decode on the word address; low two bits only feed the alignment check
  assign seg_k    = 16'hFFFF - req_addr[31:16];
  assign ram_hit  = (req_addr[31:AW+2] == '0);
  assign sw_hit   = (req_addr[31:2] == 30'h3BBB_8000);
  assign btn_hit  = (req_addr[31:2] == 30'h3BBB_8001);
  assign edge_hit = (req_addr[31:2] == 30'h3BBB_8002);
  assign stat_hit = (req_addr[31:2] == 30'h3BBB_8003);
  always_comb begin
    for (int k = 0; k < NUM_SEG; k++)
      seg_hit[k] = (req_addr[15:2] == 14'h0) && (seg_k == 16'(k));
  end

  assign errs[0] = !(ram_hit || sw_hit || btn_hit || edge_hit || stat_hit || (|seg_hit));
  assign errs[1] = |req_addr[1:0];
  assign errs[2] = req_we && (sw_hit || btn_hit || edge_hit || stat_hit);
  assign errs[3] = req_we && (req_wstrb == 4'b0000);
  assign any_err = |errs;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign do_wr     = accept && req_we && !any_err;
  assign do_rd     = accept && !req_we && !any_err;

  always_comb begin
    rd_data = '0;
    if (ram_hit) rd_data = ram[req_addr[AW+1:2]];
    if (sw_hit) rd_data[NUM_SW-1:0] = level[NUM_SW-1:0];
    if (btn_hit) rd_data[NUM_BTN-1:0] = level[NIN-1:NUM_SW];
    if (edge_hit) rd_data[NUM_BTN-1:0] = edges;
    if (stat_hit) rd_data[3:0] = status;
    for (int k = 0; k < NUM_SEG; k++)
      if (seg_hit[k]) rd_data[SEG_W-1:0] = seg_val[k];
  end

  // Read-clear registers: a same-cycle set always survives the clear
  assign edges_nxt  = ((do_rd && edge_hit) ? '0 : edges) | rise;
  assign status_nxt = ((do_rd && stat_hit) ? 4'b0000 : status) | (accept ? errs : 4'b0000);
  assign error_vector = {4'b0000, status};

  always_ff @(posedge clk) begin
    if (do_wr && ram_hit && rst)
      for (int b = 0; b < 4; b++)
        if (req_wstrb[b]) ram[req_addr[AW+1:2]][8*b +: 8] <= req_wdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edges  <= '0;
      status <= '0;
      for (int k = 0; k < NUM_SEG; k++) seg_val[k] <= '0;
    end else begin
      edges  <= edges_nxt;
      status <= status_nxt;
      for (int k = 0; k < NUM_SEG; k++)
        if (do_wr && seg_hit[k] && req_wstrb[0]) seg_val[k] <= req_wdata[SEG_W-1:0];
    end
  end

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
`ifdef MMIO_SEG_DECODE_EN
    assign seg[7*k +: 7] = hex7(seg_val[k]);
`else
    assign seg[7*k +: 7] = seg_val[k];
`endif
  end

  // Response register: one-cycle latency, held until consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= do_rd ? rd_data : 32'h0;
      rsp_err   <= any_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: doc/memory_mmio_v2.md
Name: memory_mmio_v2

Overview:
- Parametrised successor to the v1 memory unit for the RISC-V core.
- Sits between the core load/store port and board I/O. Decodes a word-aligned request into one of four targets: word RAM, NUM_SEG seven-segment registers, synchronised/debounced switches and buttons, or a sticky error register.
- Adds a valid/ready request/response handshake, byte strobes, button edge capture and read-clear status.

Parameters:
- DEPTH_WORDS, 256: RAM depth in 32-bit words. Power of 2, ≥4.
- NUM_SEG, 8: number of 7-segment channels, 1..16.
- NUM_SW, 16: switch inputs, 1..32.
- NUM_BTN, 4: button inputs, 1..32.
- DEBOUNCE_CYCLES, 16: stable cycles needed to update a debounced level, ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset (asserted at 0).
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables (writes only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  request hit an error condition.
- switch_array  in  NUM_SW  raw asynchronous switches.
- buttons  in  NUM_BTN  raw asynchronous buttons, active-high.
- seg  out  NUM_SEG*7  channel k at bits [7k+6:7k].
- error_vector  out  8  sticky error bits (mirror of STATUS).

Behaviour:
- Address map (addr[1:0] must be 00):
  - RAM: 0x0000_0000 .. 4*DEPTH_WORDS-1, read/write.
  - SEG k: 0xFFFF_0000 - k*0x0001_0000, k<NUM_SEG. Read/write; value in bits [6:0], upper bits read 0.
  - SW: 0xEEEE_0000, read-only. Debounced switches zero-extended.
  - BTN: 0xEEEE_0004, read-only. Debounced button levels.
  - EDGE: 0xEEEE_0008, read-clear. Captured rising edges.
  - STATUS: 0xEEEE_000C, read-clear. Error bits.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (combinational).
  - Exactly one response per accepted request. rsp_valid rises the cycle after accept (1-cycle latency).
  - rsp_valid and its data are held until rsp_ready.
  - Back-to-back accept is allowed in the same cycle as response consumption, giving 1 request/cycle throughput.
- RAM:
  - Synchronous, no reset of contents.
  - Write applies only the bytes with req_wstrb set.
  - Read returns the word as it was before any write in the same cycle.
- SEG writes update only when req_wstrb[0]=1; other strobes are ignored.
- Input conditioning, per switch and per button:
  - 2-flop synchroniser, then a saturating counter.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any reversion resets the counter.
- EDGE:
  - Bit i sets on a 0->1 transition of debounced button i.
  - A read returns EDGE, then clears the returned bits.
  - Set and clear in the same cycle: set wins (bit stays 1).
- Errors (rsp_err=1, write suppressed, rsp_rdata=0), each also sets a STATUS bit:
  - bit0: unmapped address.
  - bit1: misaligned address.
  - bit2: write to SW/BTN/EDGE/STATUS.
  - bit3: write with req_wstrb=0.
  - bits7:4 read 0.
- STATUS:
  - Read returns the value, then clears it. The response itself has rsp_err=0.
  - A new error in the same cycle as a clear stays set.
- Reset values (rst=0, asynchronous):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All seg channels = 7'h00, error_vector=0, EDGE=0.
  - Debounced levels=0, counters=0, synchroniser flops=0.
  - req_ready=1.
- Reset mid-transaction: the pending response is dropped and no write is committed after reset.

Optional Feature:
- MMIO_SEG_DECODE_EN defined:
  - SEG writes store req_wdata[3:0] as a hex nibble.
  - seg drives the active-low decoded pattern (0->7'h40, 8->7'h00, F->7'h0E, bit order gfedcba).
  - Reads return the nibble.
  - Reset nibble 0, so reset seg = 7'h40.
- Not defined: seg stores and drives raw req_wdata[6:0], as specified above.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb=1111, then wstrb=0010 with wdata=0x0000_5500, then read 0x10 -> rsp_rdata=0xDEAD55EF, rsp_err=0, each response one cycle after accept.
- Hold rsp_ready=0 for 3 cycles after a read of 0xEEEE_0000 with switch_array=0xA5A5 stable -> rsp_valid held, rdata=0x0000A5A5 stable, req_ready=0; second request accepted on the cycle rsp_ready=1.
- Bounce buttons[0] with 0/1 toggles every 5 cycles, then hold 1 for 20 cycles (DEBOUNCE_CYCLES=16) -> BTN bit0 rises exactly once. EDGE read returns 0x1, next EDGE read returns 0x0.
- Write to 0xEEEE_0004, then to 0x0000_0002, then read STATUS -> both error responses rsp_err=1, STATUS read 0x06, second STATUS read 0x00.
- Write 0x7F to SEG 2 (0xFFFD_0000), read it back, assert rst=0 for 1 cycle -> seg[20:14]=7'h7F, readback 0x7F, after reset seg all 0 and rsp_valid=0.
- With MMIO_SEG_DECODE_EN: write 0x8 then 0xF to SEG0 -> seg[6:0]=7'h00, then 7'h0E.
